net_link_controller: RTL and testbench

// - Far end of the processor's network path: takes netDest/netData from the register file on a SEND command,

---
 rtl/net_link_controller.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_net_link_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_link_controller.sv
// net_link_controller: frames netDest/netData into eight bytes for the Arduino
// over a 4-phase strobe/ack link, and assembles 4-byte words coming back from it.
// TX and RX run independently. Optional per-byte even parity: define NET_PARITY_EN.
module net_link_controller #(
    parameter int unsigned LINK_W  = 8,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned SYNC_ST = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sendReq,
    input  logic [31:0]       netDest,
    input  logic [31:0]       netData,
    output logic              txBusy,
    output logic              txDone,
    output logic              txError,
    output logic [LINK_W-1:0] linkOut,
    output logic              linkStrobe,
    input  logic              linkAckIn,
    input  logic [LINK_W-1:0] linkIn,
    input  logic              linkStrobeIn,
    output logic              linkAckOut,
    output logic [31:0]       netDataArduino,
    output logic              rxValid,
`ifdef NET_PARITY_EN
    output logic              linkParOut,
    input  logic              linkParIn,
    output logic              rxParErr,
`endif
    input  logic              rxAck
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned FRAME_W  = 2 * WORD_W;
    localparam int unsigned TX_BYTES = FRAME_W / LINK_W;
    localparam int unsigned RX_BYTES = WORD_W / LINK_W;
    localparam int unsigned TX_CNT_W = $clog2(TX_BYTES + 1);
    localparam int unsigned RX_CNT_W = $clog2(RX_BYTES);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_LOAD   = 3'd1;
    localparam logic [2:0] TX_DRIVE  = 3'd2;
    localparam logic [2:0] TX_WAIT_H = 3'd3;
    localparam logic [2:0] TX_WAIT_L = 3'd4;
    localparam logic [2:0] TX_DONE   = 3'd5;

    localparam logic [1:0] RX_IDLE    = 2'd0;
    localparam logic [1:0] RX_ACK     = 2'd1;
    localparam logic [1:0] RX_RELEASE = 2'd2;

    logic [SYNC_ST-1:0]  ack_sync_q,    ack_sync_d;
    logic [SYNC_ST-1:0]  strb_sync_q,   strb_sync_d;
    logic [2:0]          tx_state_q,    tx_state_d;
    logic [FRAME_W-1:0]  tx_shift_q,    tx_shift_d;
    logic [TX_CNT_W-1:0] tx_cnt_q,      tx_cnt_d;
    logic [TMO_W-1:0]    tx_tmo_q,      tx_tmo_d;
    logic                tx_busy_q,     tx_busy_d;
    logic                tx_done_q,     tx_done_d;
    logic                tx_error_q,    tx_error_d;
    logic [LINK_W-1:0]   link_out_q,    link_out_d;
    logic                link_strobe_q, link_strobe_d;
    logic [1:0]          rx_state_q,    rx_state_d;
    logic [WORD_W-1:0]   rx_shift_q,    rx_shift_d;
    logic [RX_CNT_W-1:0] rx_cnt_q,      rx_cnt_d;
    logic                link_ack_q,    link_ack_d;
    logic [WORD_W-1:0]   rx_data_q,     rx_data_d;
    logic                rx_valid_q,    rx_valid_d;
`ifdef NET_PARITY_EN
    logic                link_par_q,    link_par_d;
    logic                rx_bad_q,      rx_bad_d;
    logic                rx_par_err_q,  rx_par_err_d;
`endif

    logic ack_sync;
    logic strb_sync;
    logic tx_timeout;

    assign ack_sync   = ack_sync_q[SYNC_ST-1];
    assign strb_sync  = strb_sync_q[SYNC_ST-1];
    assign tx_timeout = (tx_tmo_q == TMO_W'(TIMEOUT - 1));

    // Synchronizer chains for the asynchronous handshake inputs
    always_comb begin
        ack_sync_d  = {ack_sync_q[SYNC_ST-2:0], linkAckIn};
        strb_sync_d = {strb_sync_q[SYNC_ST-2:0], linkStrobeIn};
    end

    // TX FSM: shift the 64-bit frame out MSB byte first, one handshake per byte
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_shift_d    = tx_shift_q;
        tx_cnt_d      = tx_cnt_q;
        tx_busy_d     = tx_busy_q;
        tx_done_d     = 1'b0;
        tx_error_d    = 1'b0;
        link_out_d    = link_out_q;
        link_strobe_d = link_strobe_q;
`ifdef NET_PARITY_EN
        link_par_d    = link_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: begin
                if (sendReq) begin
                    tx_shift_d = {netDest, netData};
                    tx_cnt_d   = '0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_LOAD;
                end
            end
            TX_LOAD: tx_state_d = TX_DRIVE;
            TX_DRIVE: begin
                link_out_d    = tx_shift_q[FRAME_W-1 -: LINK_W];
                link_strobe_d = 1'b1;
`ifdef NET_PARITY_EN
                link_par_d    = ^tx_shift_q[FRAME_W-1 -: LINK_W];
`endif
                tx_state_d    = TX_WAIT_H;
            end
            TX_WAIT_H: begin
                if (ack_sync) begin
                    link_strobe_d = 1'b0;
                    tx_state_d    = TX_WAIT_L;
                end else if (tx_timeout) begin
                    link_strobe_d = 1'b0;
                    tx_error_d    = 1'b1;
                    tx_busy_d     = 1'b0;
                    tx_state_d    = TX_IDLE;
                end
            end
            TX_WAIT_L: begin
                if (!ack_sync) begin
                    tx_shift_d = tx_shift_q << LINK_W;
                    tx_cnt_d   = tx_cnt_q + TX_CNT_W'(1);
                    if (tx_cnt_q == TX_CNT_W'(TX_BYTES - 1)) begin
                        tx_done_d  = 1'b1;
                        tx_state_d = TX_DONE;
                    end else begin
                        tx_state_d = TX_DRIVE;
                    end
                end else if (tx_timeout) begin
                    tx_error_d = 1'b1;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end
            end
            TX_DONE: begin
                tx_busy_d  = 1'b0;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Phase timer restarts on every state change and only runs while waiting on the Arduino
        if ((tx_state_d == tx_state_q) && ((tx_state_q == TX_WAIT_H) || (tx_state_q == TX_WAIT_L)))
            tx_tmo_d = tx_tmo_q + TMO_W'(1);
        else
            tx_tmo_d = '0;
    end

    // RX FSM: collect four bytes MSB first; hold off the first byte while a word is unconsumed
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        link_ack_d = link_ack_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
`ifdef NET_PARITY_EN
        rx_bad_d     = rx_bad_q;
        rx_par_err_d = 1'b0;
`endif
        if (rxAck && rx_valid_q)
            rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (strb_sync && (!rx_valid_q || (rx_cnt_q != '0))) begin
                    rx_shift_d = {rx_shift_q[WORD_W-LINK_W-1:0], linkIn};
                    link_ack_d = 1'b1;
`ifdef NET_PARITY_EN
                    if ((^linkIn) != linkParIn)
                        rx_bad_d = 1'b1;
`endif
                    rx_state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!strb_sync) begin
                    link_ack_d = 1'b0;
                    rx_state_d = RX_RELEASE;
                end
            end
            RX_RELEASE: begin
                rx_state_d = RX_IDLE;
                if (rx_cnt_q == RX_CNT_W'(RX_BYTES - 1)) begin
                    rx_cnt_d = '0;
`ifdef NET_PARITY_EN
                    if (rx_bad_q) begin
                        rx_par_err_d = 1'b1;
                        rx_bad_d     = 1'b0;
                    end else begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
`else
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
`endif
                end else begin
                    rx_cnt_d = rx_cnt_q + RX_CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_sync_q    <= '0;
            strb_sync_q   <= '0;
            tx_state_q    <= TX_IDLE;
            tx_shift_q    <= '0;
            tx_cnt_q      <= '0;
            tx_tmo_q      <= '0;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_error_q    <= 1'b0;
            link_out_q    <= '0;
            link_strobe_q <= 1'b0;
            rx_state_q    <= RX_IDLE;
            rx_shift_q    <= '0;
            rx_cnt_q      <= '0;
            link_ack_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
`ifdef NET_PARITY_EN
            link_par_q    <= 1'b0;
            rx_bad_q      <= 1'b0;
            rx_par_err_q  <= 1'b0;
`endif
        end else begin
            ack_sync_q    <= ack_sync_d;
            strb_sync_q   <= strb_sync_d;
            tx_state_q    <= tx_state_d;
            tx_shift_q    <= tx_shift_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_tmo_q      <= tx_tmo_d;
            tx_busy_q     <= tx_busy_d;
            tx_done_q     <= tx_done_d;
            tx_error_q    <= tx_error_d;
            link_out_q    <= link_out_d;
            link_strobe_q <= link_strobe_d;
            rx_state_q    <= rx_state_d;
            rx_shift_q    <= rx_shift_d;
            rx_cnt_q      <= rx_cnt_d;
            link_ack_q    <= link_ack_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
`ifdef NET_PARITY_EN
            link_par_q    <= link_par_d;
            rx_bad_q      <= rx_bad_d;
            rx_par_err_q  <= rx_par_err_d;
`endif
        end
    end

    assign txBusy         = tx_busy_q;
    assign txDone         = tx_done_q;
    assign txError        = tx_error_q;
    assign linkOut        = link_out_q;
    assign linkStrobe     = link_strobe_q;
    assign linkAckOut     = link_ack_q;
    assign netDataArduino = rx_data_q;
    assign rxValid        = rx_valid_q;
`ifdef NET_PARITY_EN
    assign linkParOut     = link_par_q;
    assign rxParErr       = rx_par_err_q;
`endif

endmodule

// File: tb/tb_net_link_controller.sv
// Bench for net_link_controller: Arduino models on both link directions with
// queue scoreboards for TX bytes and RX words. Parity checks when NET_PARITY_EN is set.
module tb_net_link_controller;

    logic        clock;
    logic        reset;
    logic        sendReq;
    logic [31:0] netDest;
    logic [31:0] netData;
    logic        txBusy;
    logic        txDone;
    logic        txError;
    logic [7:0]  linkOut;
    logic        linkStrobe;
    logic        linkAckIn;
    logic [7:0]  linkIn;
    logic        linkStrobeIn;
    logic        linkAckOut;
    logic [31:0] netDataArduino;
    logic        rxValid;
    logic        rxAck;
`ifdef NET_PARITY_EN
    logic        linkParOut;
    logic        linkParIn;
    logic        rxParErr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  tx_exp[$];
    logic [31:0] rx_exp[$];

    int   cyc;
    int   done_cnt;
    int   err_cnt;
    int   par_err_cnt;
    int   ard_state;
    int   ard_wait;
    int   ard_idx;
    int   no_ack_idx;
    int   t_strobe;
    int   t_err;
    logic rx_valid_prev;
    logic tx_busy_prev;

    net_link_controller dut (
        .clock          (clock),
        .reset          (reset),
        .sendReq        (sendReq),
        .netDest        (netDest),
        .netData        (netData),
        .txBusy         (txBusy),
        .txDone         (txDone),
        .txError        (txError),
        .linkOut        (linkOut),
        .linkStrobe     (linkStrobe),
        .linkAckIn      (linkAckIn),
        .linkIn         (linkIn),
        .linkStrobeIn   (linkStrobeIn),
        .linkAckOut     (linkAckOut),
        .netDataArduino (netDataArduino),
        .rxValid        (rxValid),
`ifdef NET_PARITY_EN
        .linkParOut     (linkParOut),
        .linkParIn      (linkParIn),
        .rxParErr       (rxParErr),
`endif
        .rxAck          (rxAck)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Arduino side of the TX link plus pulse counters and RX word monitor
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (txDone) done_cnt++;
        if (txError) begin
            err_cnt++;
            t_err = cyc;
        end
`ifdef NET_PARITY_EN
        if (rxParErr) par_err_cnt++;
`endif
        if (rxValid && !rx_valid_prev) begin
            if (rx_exp.size() > 0) check_eq("rx_word", 64'(netDataArduino), 64'(rx_exp.pop_front()));
            else check_eq("rx_unexpected_valid", 64'(rxValid), 64'd0);
        end
        rx_valid_prev = rxValid;
        if (reset) begin
            ard_state = 0;
            ard_idx   = 0;
            linkAckIn = 1'b0;
        end else begin
            if (txBusy && !tx_busy_prev) ard_idx = 0;
            case (ard_state)
                0: if (linkStrobe) begin
                    if (tx_exp.size() > 0) check_eq("tx_byte", 64'(linkOut), 64'(tx_exp.pop_front()));
                    else check_eq("tx_extra_strobe", 64'(linkStrobe), 64'd0);
`ifdef NET_PARITY_EN
                    check_eq("tx_parity", 64'(linkParOut), 64'(^linkOut));
`endif
                    ard_wait = 0;
                    if (ard_idx == no_ack_idx) begin
                        ard_state = 3;
                        t_strobe  = cyc;
                    end else begin
                        ard_state = 1;
                    end
                    ard_idx++;
                end
                1: begin
                    ard_wait++;
                    if (ard_wait >= 5) begin
                        linkAckIn = 1'b1;
                        ard_state = 2;
                    end
                end
                2: if (!linkStrobe) begin
                    linkAckIn = 1'b0;
                    ard_state = 0;
                end
                default: if (!linkStrobe) ard_state = 0;
            endcase
        end
        tx_busy_prev = txBusy;
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_txBusy"},     64'(txBusy),         64'd0);
        check_eq({tag, "_txDone"},     64'(txDone),         64'd0);
        check_eq({tag, "_txError"},    64'(txError),        64'd0);
        check_eq({tag, "_linkOut"},    64'(linkOut),        64'd0);
        check_eq({tag, "_linkStrobe"}, 64'(linkStrobe),     64'd0);
        check_eq({tag, "_linkAckOut"}, 64'(linkAckOut),     64'd0);
        check_eq({tag, "_netData"},    64'(netDataArduino), 64'd0);
        check_eq({tag, "_rxValid"},    64'(rxValid),        64'd0);
    endtask

    task automatic send_frame(input logic [31:0] dest, input logic [31:0] data);
        logic [63:0] f;
        f = {dest, data};
        for (int i = 0; i < 8; i++) tx_exp.push_back(f[63-8*i -: 8]);
        @(negedge clock);
        netDest = dest;
        netData = data;
        sendReq = 1'b1;
        @(negedge clock);
        sendReq = 1'b0;
        check_eq("tx_busy_rise", 64'(txBusy), 64'd1);
    endtask

    task automatic wait_tx_idle(input int budget);
        int n = 0;
        while (txBusy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq("tx_idle", 64'(txBusy), 64'd0);
    endtask

    task automatic wait_ack_out(input logic v, input string tag);
        int n = 0;
        while (linkAckOut !== v && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, 64'(linkAckOut), 64'(v));
    endtask

    task automatic send_rx_byte(input logic [7:0] b, input logic bad_par);
        wait_ack_out(1'b0, "rx_ack_idle");
        linkIn = b;
`ifdef NET_PARITY_EN
        linkParIn = (^b) ^ bad_par;
`else
        if (bad_par) linkIn = b;
`endif
        linkStrobeIn = 1'b1;
        wait_ack_out(1'b1, "rx_ack_high");
        linkStrobeIn = 1'b0;
        wait_ack_out(1'b0, "rx_ack_low");
    endtask

    task automatic send_word(input logic [31:0] w, input int bad_idx);
        for (int i = 0; i < 4; i++) send_rx_byte(w[31-8*i -: 8], i == bad_idx);
    endtask

    task automatic wait_rx_valid(input string tag);
        int n = 0;
        while (!rxValid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, 64'(rxValid), 64'd1);
    endtask

    task automatic rx_ack_pulse();
        @(negedge clock);
        rxAck = 1'b1;
        @(negedge clock);
        rxAck = 1'b0;
        check_eq("rx_ack_clears", 64'(rxValid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;
        reset        = 1'b1;
        sendReq      = 1'b0;
        netDest      = '0;
        netData      = '0;
        linkIn       = '0;
        linkStrobeIn = 1'b0;
        rxAck        = 1'b0;
        no_ack_idx   = -1;
`ifdef NET_PARITY_EN
        linkParIn    = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Full frame, with a second request during the frame that must be dropped
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(32'h0000_0003, 32'hDEAD_BEEF);
        repeat (20) @(negedge clock);
        netDest = 32'hFFFF_FFFF;
        netData = 32'h0;
        sendReq = 1'b1;
        @(negedge clock);
        sendReq = 1'b0;
        wait_tx_idle(2000);
        repeat (3) @(negedge clock);
        check_eq("tx_done_pulses", 64'(done_cnt - d0), 64'd1);
        check_eq("tx_no_error", 64'(err_cnt - e0), 64'd0);
        check_eq("tx_bytes_left", 64'(tx_exp.size()), 64'd0);
        check_eq("tx_strobe_low", 64'(linkStrobe), 64'd0);

        // Arduino never acks byte 3: abort after TIMEOUT cycles in WAIT_H
        no_ack_idx = 3;
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(32'h0102_0304, 32'h0506_0708);
        wait_tx_idle(3000);
        repeat (3) @(negedge clock);
        check_eq("tmo_error_pulses", 64'(err_cnt - e0), 64'd1);
        check_eq("tmo_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("tmo_strobe_low", 64'(linkStrobe), 64'd0);
        check_eq("tmo_cycles", 64'(t_err - t_strobe), 64'd1000);
        check_eq("tmo_bytes_unsent", 64'(tx_exp.size()), 64'd4);
        tx_exp.delete();
        no_ack_idx = -1;

        // Receive one word and consume it
        rx_exp.push_back(32'h1234_5678);
        send_word(32'h1234_5678, -1);
        wait_rx_valid("rx_valid_set");
        rx_ack_pulse();

        // Backpressure: second word waits for the first to be consumed
        rx_exp.push_back(32'hCAFE_F00D);
        send_word(32'hCAFE_F00D, -1);
        wait_rx_valid("bp_first_valid");
        rx_exp.push_back(32'h0BAD_C0DE);
        fork
            send_word(32'h0BAD_C0DE, -1);
            begin
                repeat (30) @(negedge clock);
                check_eq("bp_no_ack", 64'(linkAckOut), 64'd0);
                check_eq("bp_still_valid", 64'(rxValid), 64'd1);
                check_eq("bp_word_held", 64'(netDataArduino), 64'h0000_0000_CAFE_F00D);
                rx_ack_pulse();
            end
        join
        wait_rx_valid("bp_second_valid");
        rx_ack_pulse();

        // Reset during TX byte 5, then a clean frame
        d0 = done_cnt;
        send_frame(32'hA1A2_A3A4, 32'hB1B2_B3B4);
        begin
            int n = 0;
            while (ard_idx != 6 && n < 500) begin
                @(negedge clock);
                n++;
            end
        end
        check_eq("tx_reached_byte5", 64'(ard_idx), 64'd6);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("rst_tx");
        tx_exp.delete();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_tx_no_done", 64'(done_cnt - d0), 64'd0);
        send_frame(32'h0000_0007, 32'h7654_3210);
        wait_tx_idle(2000);
        repeat (3) @(negedge clock);
        check_eq("rst_tx_next_done", 64'(done_cnt - d0), 64'd1);
        check_eq("rst_tx_next_bytes", 64'(tx_exp.size()), 64'd0);

        // Reset during RX byte 2, then a clean word
        rx_exp.push_back(32'h5566_7788);
        send_word(32'h5566_7788, -1);
        wait_rx_valid("pre_rst_rx_valid");
        rx_ack_pulse();
        send_rx_byte(8'h11, 1'b0);
        send_rx_byte(8'h22, 1'b0);
        linkIn       = 8'h33;
        linkStrobeIn = 1'b1;
        wait_ack_out(1'b1, "rx_b2_ack");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("rst_rx");
        linkStrobeIn = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        rx_exp.push_back(32'h9ABC_DEF0);
        send_word(32'h9ABC_DEF0, -1);
        wait_rx_valid("rst_rx_next_valid");
        rx_ack_pulse();

`ifdef NET_PARITY_EN
        // Bad parity on one byte: word discarded, error pulsed
        d0 = par_err_cnt;
        send_word(32'hAABB_CCDD, 2);
        repeat (4) @(negedge clock);
        check_eq("par_err_pulse", 64'(par_err_cnt - d0), 64'd1);
        check_eq("par_no_valid", 64'(rxValid), 64'd0);
        check_eq("par_word_kept", 64'(netDataArduino), 64'h0000_0000_9ABC_DEF0);
`endif

        repeat (5) @(negedge clock);
        check_eq("rx_queue_empty", 64'(rx_exp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
